output_store_cdf: RTL and testbench
===================================

// Module: output_store_cdf
// PURPOSE
//  Write-side counterpart of the output-pipeline CDF fetch stage. Accepts a stream of
//  histogram bin counts and forms the running cumulative sum (CDF). Writes one CDF entry
//  per bin into the 128-bit-wide CDF SRAM.
//  Each entry sits in WriteBus[19:0] and bits [127:20] are zero, so the fetch stage can
//  read the entry back from ReadBus[19:0].
//  Sits between the histogram counter and the CDF SRAM write port.
// PARAMETERS
//  NUM_BINS   256  number of histogram bins (entries written per frame)
//  DATA_W     20   CDF entry width; the running sum saturates at 2**DATA_W-1
//  BUS_W      128  SRAM word width
//  ADDR_W     12   SRAM address width
//  BASE_ADDR  0    SRAM address of bin 0
// PORTS
//  clock      in   1       rising-edge clock
//  reset_n    in   1       asynchronous, active-low reset
//  StartIn    in   1       one-cycle pulse: begin a new CDF frame
//  BinValid   in   1       BinCount is valid this cycle
//  BinCount   in   DATA_W  histogram count for the next bin, delivered in bin order 0..NUM_BINS-1
//  BinReady   out  1       block accepts a bin this cycle (BinValid && BinReady = transfer)
//  WriteEn    out  1       SRAM write strobe
//  WriteAddr  out  ADDR_W  SRAM write address
//  WriteBus   out  BUS_W   SRAM write data: {zeros, cdf[DATA_W-1:0]}
//  Busy       out  1       frame in progress
//  DoneOut    out  1       one-cycle pulse after the last entry is written
// BEHAVIOUR
//  Reset values: every output is 0 (WriteBus = 128'd0, never X). The FSM goes to IDLE,
//  the sum and the bin index clear to 0.
//  FSM states and transitions:
//   IDLE -> RUN on StartIn. On that edge: sum <= 0, idx <= 0, Busy <= 1.
//   RUN: BinReady = 1 (combinational from state).
//    - Each transfer: s = sum + BinCount, computed DATA_W+1 bits wide.
//    - If s overflows, clamp s to 2**DATA_W-1. Once saturated, sum stays saturated.
//    - Register sum <= s.
//    - WriteEn <= 1, WriteAddr <= BASE_ADDR + idx, WriteBus <= {zeros, s}.
//    - idx <= idx + 1.
//    - Latency is 1 clock from transfer to the WriteEn cycle.
//    - A cycle with no transfer gives WriteEn <= 0. In that case WriteAddr and WriteBus
//      hold their last values.
//    - The transfer with idx == NUM_BINS-1 moves the FSM to DONE.
//   DONE (one cycle): WriteEn for the last entry is high here. BinReady = 0.
//    DoneOut <= 1 for the next cycle, Busy <= 0, then the FSM returns to IDLE.
//  BinReady is 0 in IDLE and DONE. BinValid in those states is ignored and does not
//  change the sum or the index.
//  StartIn in RUN or DONE is ignored; the current frame completes normally.
//  StartIn in the same cycle as DoneOut: the FSM is already in IDLE, so StartIn is
//  accepted and a new frame starts. This gives back-to-back frames.
//  WriteBus[BUS_W-1:DATA_W] is 0 at all times.
//  Address: WriteAddr = BASE_ADDR + idx, modulo 2**ADDR_W (wraps silently).
//  Exactly NUM_BINS writes occur per frame, to consecutive addresses.
//  Reset mid-frame: all state clears at once. No further writes occur until the next StartIn.
// TESTING
//  1. Reset: assert reset_n=0 mid-RUN
//     -> all outputs 0 and BinReady=0 in the same cycle; no WriteEn until the next StartIn.
//  2. Ramp: StartIn, then 256 bins of BinCount=1 with BinValid held high
//     -> writes addr 0..255 with data 1..256; DoneOut pulses 2 cycles after the last transfer.
//  3. Gaps: BinValid toggled 1,0,0,1 with counts 5,x,x,7
//     -> WriteEn pattern 1,0,0,1; data 5 then 12; addresses 0 then 1.
//  4. Saturation: bin0 = 20'hFFFF0, bin1 = 20'h00020, bin2 = 0
//     -> entries 20'hFFFF0, 20'hFFFFF, 20'hFFFFF; upper 108 bits zero.
//  5. Ignored starts: StartIn pulsed at bin 100 of a running frame
//     -> the frame completes with 256 writes and an unchanged sum.
//  6. Back-to-back: StartIn asserted in the DoneOut cycle
//     -> the new frame's first write has addr = BASE_ADDR and data = bin0 count only.

Source files
------------

// File: rtl/output_store_cdf.sv
// output_store_cdf
//   Write side of the output-pipeline CDF path. Takes histogram bin counts in
//   bin order, accumulates a saturating running sum, and writes one CDF entry
//   per bin into the CDF SRAM. The entry is placed in WriteBus[DATA_W-1:0] and
//   the rest of the word is zero, so the fetch stage reads it from the low bits.
//
//   Ports
//     clock      rising-edge clock
//     reset_n    asynchronous, active-low reset
//     StartIn    one-cycle pulse, begins a frame (accepted only when idle)
//     BinValid   BinCount valid this cycle
//     BinCount   histogram count of the next bin
//     BinReady   high while a frame is running; BinValid && BinReady = transfer
//     WriteEn    SRAM write strobe, one cycle after each transfer
//     WriteAddr  SRAM write address (BASE_ADDR + bin index, wraps)
//     WriteBus   SRAM write data {zeros, cdf}
//     Busy       frame in progress
//     DoneOut    one-cycle pulse after the last entry has been written
module output_store_cdf #(
  parameter int NUM_BINS  = 256,
  parameter int DATA_W    = 20,
  parameter int BUS_W     = 128,
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              StartIn,
  input  logic              BinValid,
  input  logic [DATA_W-1:0] BinCount,
  output logic              BinReady,
  output logic              WriteEn,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic [BUS_W-1:0]  WriteBus,
  output logic              Busy,
  output logic              DoneOut
);

  localparam int IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BINS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] sum_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic [DATA_W-1:0] wr_data_p1;
  logic [DATA_W-1:0] sum_next;
  logic              transfer;

  // Add one extra bit wide and clamp on carry-out. A saturated sum stays at
  // all-ones because any further addition also carries out (or adds zero).
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
  endfunction

  assign BinReady = (state == RUN);
  assign transfer = BinValid && BinReady;
  assign sum_next = sat_add(sum_p0, BinCount);

  // Only the low DATA_W bits are stored; the upper bus bits are constant zero.
  assign WriteBus = BUS_W'(wr_data_p1);

  // p0 -> p1: accumulate and register the SRAM write one cycle after transfer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sum_p0     <= '0;
      idx_p0     <= '0;
      WriteEn    <= 1'b0;
      WriteAddr  <= '0;
      wr_data_p1 <= '0;
      Busy       <= 1'b0;
      DoneOut    <= 1'b0;
    end else begin
      WriteEn <= 1'b0;
      DoneOut <= 1'b0;
      case (state)
        IDLE: begin
          if (StartIn) begin
            sum_p0 <= '0;
            idx_p0 <= '0;
            Busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (transfer) begin
            sum_p0     <= sum_next;
            wr_data_p1 <= sum_next;
            WriteEn    <= 1'b1;
            WriteAddr  <= BASE + ADDR_W'(idx_p0);
            idx_p0     <= idx_p0 + IDX_W'(1);
            if (idx_p0 == LAST_IDX) state <= DONE;
          end
        end
        DONE: begin
          DoneOut <= 1'b1;
          Busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_store_cdf.sv
module tb_output_store_cdf;

  logic         clock;
  logic         reset_n;
  logic         StartIn;
  logic         BinValid;
  logic [19:0]  BinCount;
  logic         BinReady;
  logic         WriteEn;
  logic [11:0]  WriteAddr;
  logic [127:0] WriteBus;
  logic         Busy;
  logic         DoneOut;

  int total = 0;
  int bad   = 0;

  output_store_cdf dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .StartIn  (StartIn),
    .BinValid (BinValid),
    .BinCount (BinCount),
    .BinReady (BinReady),
    .WriteEn  (WriteEn),
    .WriteAddr(WriteAddr),
    .WriteBus (WriteBus),
    .Busy     (Busy),
    .DoneOut  (DoneOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    128'(WriteEn),   128'd0);
    chk({tag, "_addr"},  128'(WriteAddr), 128'd0);
    chk({tag, "_bus"},   WriteBus,        128'd0);
    chk({tag, "_busy"},  128'(Busy),      128'd0);
    chk({tag, "_done"},  128'(DoneOut),   128'd0);
    chk({tag, "_ready"}, 128'(BinReady),  128'd0);
  endtask

  logic        gap_v [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [19:0] gap_c [4] = '{20'd5, 20'd3, 20'd3, 20'd7};
  logic        gap_we[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int          gap_a [4] = '{0, 0, 0, 1};
  int          gap_d [4] = '{5, 5, 5, 12};
  logic [19:0] sat_c [3] = '{20'hFFFF0, 20'h00020, 20'h00000};
  logic [19:0] sat_d [3] = '{20'hFFFF0, 20'hFFFFF, 20'hFFFFF};

  initial begin
    reset_n  = 1'b1;
    StartIn  = 1'b0;
    BinValid = 1'b0;
    BinCount = '0;
    #2 reset_n = 1'b0;
    tick();
    tick();
    chk_all_zero("por");
    reset_n = 1'b1;
    tick();
    chk("idle_ready", 128'(BinReady), 128'd0);

    // Ramp of ones, with an ignored StartIn pulse at bin 100
    StartIn = 1'b1;
    tick();
    StartIn = 1'b0;
    chk("start_busy",  128'(Busy),     128'd1);
    chk("start_ready", 128'(BinReady), 128'd1);
    chk("start_we",    128'(WriteEn),  128'd0);
    BinValid = 1'b1;
    BinCount = 20'd1;
    for (int i = 0; i < 256; i++) begin
      StartIn = (i == 100);
      tick();
      chk("ramp_we",    128'(WriteEn),   128'd1);
      chk("ramp_addr",  128'(WriteAddr), 128'(i));
      chk("ramp_bus",   WriteBus,        128'(i + 1));
      chk("ramp_ready", 128'(BinReady),  (i == 255) ? 128'd0 : 128'd1);
    end
    StartIn  = 1'b0;
    BinCount = 20'd9;
    chk("done_st_pulse", 128'(DoneOut), 128'd0);
    chk("done_st_busy",  128'(Busy),    128'd1);
    tick();
    chk("doneout",      128'(DoneOut),   128'd1);
    chk("doneout_busy", 128'(Busy),      128'd0);
    chk("doneout_we",   128'(WriteEn),   128'd0);
    chk("hold_addr",    128'(WriteAddr), 128'd255);
    chk("hold_bus",     WriteBus,        128'd256);

    // Back-to-back frame started in the DoneOut cycle, then gaps
    StartIn = 1'b1;
    tick();
    StartIn = 1'b0;
    chk("b2b_done",  128'(DoneOut),  128'd0);
    chk("b2b_busy",  128'(Busy),     128'd1);
    chk("b2b_ready", 128'(BinReady), 128'd1);
    for (int i = 0; i < 4; i++) begin
      BinValid = gap_v[i];
      BinCount = gap_c[i];
      tick();
      chk("gap_we",   128'(WriteEn),   128'(gap_we[i]));
      chk("gap_addr", 128'(WriteAddr), 128'(gap_a[i]));
      chk("gap_bus",  WriteBus,        128'(gap_d[i]));
    end
    BinValid = 1'b1;
    BinCount = 20'd4;
    tick();
    chk("pre_rst_addr", 128'(WriteAddr), 128'd2);
    chk("pre_rst_bus",  WriteBus,        128'd16);

    // Asynchronous reset in the middle of a running frame
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("post_rst_we",    128'(WriteEn),  128'd0);
      chk("post_rst_ready", 128'(BinReady), 128'd0);
      chk("post_rst_busy",  128'(Busy),     128'd0);
    end

    // Saturation frame
    BinValid = 1'b0;
    StartIn  = 1'b1;
    tick();
    StartIn  = 1'b0;
    BinValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      BinCount = sat_c[i];
      tick();
      chk("sat_we",   128'(WriteEn),   128'd1);
      chk("sat_addr", 128'(WriteAddr), 128'(i));
      chk("sat_bus",  WriteBus,        128'(sat_d[i]));
    end
    BinCount = 20'd1;
    for (int i = 3; i < 256; i++) begin
      tick();
      chk("satrun_we",   128'(WriteEn),   128'd1);
      chk("satrun_addr", 128'(WriteAddr), 128'(i));
      chk("satrun_bus",  WriteBus,        128'h000FFFFF);
    end
    BinValid = 1'b0;
    chk("sat_last_ready", 128'(BinReady), 128'd0);
    tick();
    chk("sat_doneout", 128'(DoneOut), 128'd1);
    chk("sat_end_we",  128'(WriteEn), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
